// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-port req/gnt arbiter in front of the single-port data memory (port 0 = CPU, port 1 = debug/DMA).
// Round-robin by default; define DMEM_ARB_CPU_PRIO_EN for fixed port-0 priority.
module dmem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    dmem_bus_arbiter_if.slave        bus,
    output logic                     busy,
    output logic                     last_owner
);
    localparam int CW = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
            $error("dmem_bus_arbiter: MEM_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   last_owner_q, last_owner_d;
    logic [1:0][DW-1:0]     rdata_q, rdata_d;
    logic [1:0]             rvalid_q, rvalid_d;

    logic [1:0]             req;
    logic [1:0]             we_in;
    logic [1:0][AW-1:0]     addr_in;
    logic [1:0][DW-1:0]     wdata_in;
    logic                   win;
    logic                   mem_en;

    assign req      = {bus.m1_req,   bus.m0_req};
    assign we_in    = {bus.m1_we,    bus.m0_we};
    assign addr_in  = {bus.m1_addr,  bus.m0_addr};
    assign wdata_in = {bus.m1_wdata, bus.m0_wdata};

    // Winner among the current requesters; only meaningful when |req.
    always_comb begin
        win = 1'b0;
`ifdef DMEM_ARB_CPU_PRIO_EN
        win = ~req[0];
`else
        if (req == 2'b11) win = ~last_owner_q;
        else              win = req[1];
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        rdata_d      = rdata_q;
        rvalid_d     = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = win;
                    we_d    = we_in[win];
                    addr_d  = addr_in[win];
                    wdata_d = wdata_in[win];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                last_owner_d = owner_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                // Counter hits zero in the cycle mem_rdata is valid.
                if (cnt_q == '0) begin
                    rdata_d[owner_q]  = bus.mem_rdata;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
            rdata_q      <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign mem_en        = (state_q == ACCESS);
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_en & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.m0_gnt    = mem_en & ~owner_q;
    assign bus.m1_gnt    = mem_en &  owner_q;
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];

    assign busy       = (state_q != IDLE);
    assign last_owner = last_owner_q;
endmodule
